ram_mem: RTL and testbench
==========================

// Module: ram_mem
// PURPOSE
//   Single-port-write / single-port-read word RAM mapped into the system bus address space.
//   Occupies MEM_SIZE consecutive word addresses starting at ADDR_BASE.
//   Addresses outside that window are ignored on write and read as zero.
//   Serves as the data/scratch RAM slave behind the bus address decoder.
// PARAMETERS
//   BUS_WIDTH  32  width of address and data buses (bits)
//   ADDR_BASE  10  first word address owned by this RAM (word addressing, not byte)
//   MEM_SIZE   32  number of BUS_WIDTH-bit words stored
// PORTS
//   clk         in   1          single clock; all state changes on rising edge
//   reset       in   1          synchronous, active-high reset
//   write_en    in   1          write strobe, sampled on rising clk edge
//   addr_write  in   BUS_WIDTH  word address of write
//   data_write  in   BUS_WIDTH  write data
//   addr_read   in   BUS_WIDTH  word address of read
//   data_read   out  BUS_WIDTH  read data (combinational)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Range check: in_range(a) = (a >= ADDR_BASE) && (a < ADDR_BASE+MEM_SIZE).
//     Evaluate at BUS_WIDTH+1 bits so the upper bound cannot overflow.
//     Index = a - ADDR_BASE (width clog2(MEM_SIZE)).
//   - Reset: on a rising edge with reset=1, every word is cleared to 0.
//     Reset has priority over a write on the same edge.
//     Reset asserted mid-operation discards all contents.
//   - Write: on a rising edge with reset=0, write_en=1 and in_range(addr_write),
//     mem[index] <= data_write. Out-of-range writes are dropped silently.
//     No aliasing or wrap-around into the array.
//   - write_en held high across several edges writes on every edge.
//     The last data_write sampled wins.
//   - Read: asynchronous, zero latency. data_read = mem[index(addr_read)] if
//     in_range(addr_read), else 0.
//   - Read/write same address: data_read shows the old word until the write edge,
//     then the new word in the same cycle after that edge. No bypass before the edge.
//   - data_read after reset = 0 for every address.
//   - No X propagation: the array must not power up as X-visible after reset.
// STRUCTURE
//   - Shared package: none required. Optionally ADDR_IDX_W = $clog2(MEM_SIZE) as a
//     localparam in this file.
//   - Sub-module ram_mem_addr_dec (instantiated twice, write and read side).
//     Inputs: addr. Outputs: hit, idx. Holds the range check and subtraction.
//   - Storage: reg array [0:MEM_SIZE-1] of BUS_WIDTH bits.
//     Cleared by a for-loop in the synchronous reset branch.
// TESTING (BUS_WIDTH=32, ADDR_BASE=10, MEM_SIZE=32, clk period 1 us)
//   1. Pulse reset 2 cycles, addr_read=10 -> data_read=0; also reads 41 -> 0.
//   2. addr_write=11, data_write=2, write_en=1 for 1 edge, addr_read=11 -> data_read=2.
//      Then data_write=1, write_en still 1, next edge -> data_read=1.
//   3. write_en=0, change data_write/addr_write to 41 with data 1 over several edges
//      -> mem[41] stays 0 and addr 11 still reads 1.
//   4. addr_write=41 (last word), data_write=1, write_en=1 for 2 edges, addr_read=41
//      -> data_read=1.
//   5. Out of range: addr_read=42 -> 0, addr_read=9 -> 0.
//      Write 0xDEAD to 42 and to 9 -> addr 10 and addr 41 unchanged (no aliasing).
//   6. Assert reset on the same edge as write_en=1 to addr 12 with data 7.
//      -> addr 12 reads 0 and addr 11/41 read 0 afterwards (reset wins, full clear).

Source files
------------

// File: rtl/ram_mem_pkg.sv
// Shared helpers for the bus-mapped word RAM.
package ram_mem_pkg;

  // Index width; at least one bit so a single-word RAM still gets a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_mem_addr_dec.sv
// Window decode: hit when addr lies in [ADDR_BASE, ADDR_BASE+MEM_SIZE), idx = addr - ADDR_BASE.
module ram_mem_addr_dec
  import ram_mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_BASE = 10,
  parameter int MEM_SIZE  = 32,
  parameter int IDX_W     = idx_w(MEM_SIZE)
) (
  input  logic [BUS_WIDTH-1:0] addr,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  // One extra bit keeps ADDR_BASE+MEM_SIZE from wrapping near the top of the bus.
  localparam logic [BUS_WIDTH:0] LO = (BUS_WIDTH+1)'(ADDR_BASE);
  localparam logic [BUS_WIDTH:0] HI = (BUS_WIDTH+1)'(ADDR_BASE + MEM_SIZE);

  logic [BUS_WIDTH:0] a_ext;

  always_comb begin
    a_ext = {1'b0, addr};
    hit   = (a_ext >= LO) && (a_ext < HI);
    idx   = IDX_W'(a_ext - LO);
  end

endmodule

// File: rtl/ram_mem.sv
// Bus-mapped word RAM: synchronous write, combinational read, sync active-high clear.
module ram_mem
  import ram_mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_BASE = 10,
  parameter int MEM_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [BUS_WIDTH-1:0] addr_write,
  input  logic [BUS_WIDTH-1:0] data_write,
  input  logic [BUS_WIDTH-1:0] addr_read,
  output logic [BUS_WIDTH-1:0] data_read
);

  localparam int ADDR_IDX_W = idx_w(MEM_SIZE);

  logic [BUS_WIDTH-1:0]  mem [0:MEM_SIZE-1];
  logic                  wr_hit, rd_hit;
  logic [ADDR_IDX_W-1:0] wr_idx, rd_idx;

  ram_mem_addr_dec #(
    .BUS_WIDTH(BUS_WIDTH), .ADDR_BASE(ADDR_BASE), .MEM_SIZE(MEM_SIZE), .IDX_W(ADDR_IDX_W)
  ) u_wr_dec (
    .addr(addr_write), .hit(wr_hit), .idx(wr_idx)
  );

  ram_mem_addr_dec #(
    .BUS_WIDTH(BUS_WIDTH), .ADDR_BASE(ADDR_BASE), .MEM_SIZE(MEM_SIZE), .IDX_W(ADDR_IDX_W)
  ) u_rd_dec (
    .addr(addr_read), .hit(rd_hit), .idx(rd_idx)
  );

  // Reset clears every word and beats a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else if (write_en && wr_hit) begin
      mem[wr_idx] <= data_write;
    end
  end

  always_comb begin
    data_read = '0;
    if (rd_hit) data_read = mem[rd_idx];
  end

endmodule

// File: tb/tb_ram_mem.sv
// Directed checks for ram_mem: clear, write/readback, window edges, aliasing, reset priority.
`timescale 1ns/1ps
module tb_ram_mem;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_en;
  logic [BW-1:0] addr_write, data_write, addr_read, data_read;

  int total = 0;
  int bad   = 0;

  ram_mem #(.BUS_WIDTH(BW), .ADDR_BASE(10), .MEM_SIZE(32)) dut (
    .clk(clk), .reset(reset), .write_en(write_en),
    .addr_write(addr_write), .data_write(data_write),
    .addr_read(addr_read), .data_read(data_read)
  );

  always #500 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] exp);
    addr_read = a;
    #1;
    chk(tag, data_read, exp);
  endtask

  initial begin
    reset = 1'b1; write_en = 1'b0;
    addr_write = '0; data_write = '0; addr_read = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: cleared contents
    rd("rst_10", 32'd10, 32'd0);
    rd("rst_41", 32'd41, 32'd0);
    rd("rst_25", 32'd25, 32'd0);

    // 2: write, then held write_en with new data; no bypass before the edge
    addr_write = 32'd11; data_write = 32'd2; write_en = 1'b1;
    rd("wr11_pre", 32'd11, 32'd0);
    tick();
    rd("wr11_a", 32'd11, 32'd2);
    data_write = 32'd1;
    rd("wr11_hold_pre", 32'd11, 32'd2);
    tick();
    rd("wr11_b", 32'd11, 32'd1);

    // 3: write_en low blocks writes
    write_en = 1'b0; addr_write = 32'd41; data_write = 32'd1;
    tick(); tick(); tick();
    rd("we0_41", 32'd41, 32'd0);
    rd("we0_11", 32'd11, 32'd1);

    // 4: last word
    write_en = 1'b1;
    tick(); tick();
    write_en = 1'b0;
    rd("last_41", 32'd41, 32'd1);

    // 5: out of range reads and writes; seed addr 10 so aliasing shows up
    addr_write = 32'd10; data_write = 32'h55; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    rd("seed_10", 32'd10, 32'h55);
    rd("oor_rd_42", 32'd42, 32'd0);
    rd("oor_rd_9", 32'd9, 32'd0);
    rd("oor_rd_max", 32'hFFFF_FFFF, 32'd0);
    write_en = 1'b1; data_write = 32'hDEAD;
    addr_write = 32'd42; tick();
    addr_write = 32'd9;  tick();
    addr_write = 32'hFFFF_FFFF; tick();
    write_en = 1'b0;
    rd("alias_10", 32'd10, 32'h55);
    rd("alias_41", 32'd41, 32'd1);
    rd("alias_11", 32'd11, 32'd1);

    // 6: reset beats a write on the same edge and clears everything
    reset = 1'b1; write_en = 1'b1; addr_write = 32'd12; data_write = 32'd7;
    tick();
    reset = 1'b0; write_en = 1'b0;
    rd("rstw_12", 32'd12, 32'd0);
    rd("rstw_11", 32'd11, 32'd0);
    rd("rstw_41", 32'd41, 32'd0);
    rd("rstw_10", 32'd10, 32'd0);

    // post-reset write still works
    write_en = 1'b1; addr_write = 32'd25; data_write = 32'hA5A5_0F0F;
    tick();
    write_en = 1'b0;
    rd("post_25", 32'd25, 32'hA5A5_0F0F);
    rd("post_26", 32'd26, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
